wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
Write-back port arbiter for the dual-issue core. It merges the two in-order pipeline write-back slots with results from the long-latency unit (divider and miss-path loads) onto the register file's two write ports. Pipeline slots always own their port. Long-latency results wait in a small FIFO and drain into whichever ports are idle. It also exports a mask of registers whose results are still queued, used for stall and forwarding decisions.

Parameters:
DEPTH, 4, long-latency result FIFO entries (power of two, >=2)
CW, 3, width of the q_count output (log2(DEPTH)+1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
slot1_valid  in  1  slot 1 result valid
slot1_we  in  1  slot 1 writes the GPR
slot1_dest  in  5  slot 1 destination register
slot1_data  in  32  slot 1 result
slot1_pc  in  32  slot 1 PC (debug)
slot2_valid/slot2_we/slot2_dest/slot2_data/slot2_pc  in  1/1/5/32/32  same fields for slot 2 (younger)
lu_valid  in  1  long-latency result offered
lu_ready  out  1  arbiter accepts the long-latency result
lu_dest  in  5  long-latency destination
lu_data  in  32  long-latency result
lu_pc  in  32  long-latency PC
rf_we1/rf_waddr1/rf_wdata1/rf_pc1  out  1/5/32/32  RF write port 1 (registered)
rf_we2/rf_waddr2/rf_wdata2/rf_pc2  out  1/5/32/32  RF write port 2 (registered)
pend_mask  out  32  bit d=1 while a queued entry targets register d
q_count  out  CW  FIFO occupancy

Behaviour:
- Clock is clk. Reset is synchronous and active-high, on port reset; all state updates on the rising edge of clk.
- Reset effects: FIFO empty; q_count=0; pend_mask=0; all rf_* outputs 0; lu_ready=0 while reset is high.
- lu_ready = !reset && (q_count < DEPTH).
  - Based on registered occupancy only. No fall-through: a full FIFO refuses lu_valid even if it drains in the same cycle.
- Accept: lu_valid && lu_ready.
  - lu_dest==0: consumed and discarded, never enqueued.
  - Otherwise appended at the tail.
- Port ownership each cycle:
  - Port 1 is busy iff slot1_valid && slot1_we. Port 2 is busy iff slot2_valid && slot2_we.
  - A busy port carries its slot's dest, data and pc.
- Drain: idle ports take entries in FIFO order. The candidate list is the queued entries followed by the entry accepted this cycle.
  - Both ports idle: the oldest entry goes to port 1, the next to port 2.
  - One port idle: the oldest entry goes to that port.
  - So up to 2 entries drain per cycle. A newly accepted entry may be written out the same cycle when the FIFO is empty and a port is idle.
- Occupancy: q_count_next = q_count + (enqueued) - (drained). Pointers wrap modulo DEPTH.
- Same-destination rule: if both ports are enabled with equal addresses, rf_we1 is forced to 0 and port 2 wins.
  - Port 2 always carries the younger write: slot 2 over slot 1, or the second-oldest queue entry over the oldest.
- Ordering guarantee: the upstream scoreboard never issues a pipeline instruction whose dest matches a pending long-latency dest. The arbiter does not check this and does not handle it.
- Output timing: all rf_* outputs are registered, one cycle after slot inputs or drain. Idle port: we=0, addr/data/pc=0.
- pend_mask is computed combinationally from valid FIFO entries after the edge, so it excludes entries drained that cycle.
- Reset mid-operation: queued entries are discarded; no write is produced on the cycle after reset.

Test Plan:
- Reset, then slot1 (we=1, dest=5, data=0x11) and slot2 (we=1, dest=6, data=0x22) → next cycle rf_we1=1 addr5 0x11, rf_we2=1 addr6 0x22; lu_ready=1.
- Both slots write dest=7 (0xAA, 0xBB) → rf_we1=0; rf_we2=1 addr7 0xBB.
- Both slots busy for 6 cycles while lu offers dests 1,2,3,4,5 → first 4 accepted; lu_ready=0 at q_count=4; pend_mask=0x1E. Slots go idle → entries 1,2 written next cycle on ports 1,2, then 3,4 the cycle after. pend_mask reaches 0.
- Slot1 busy, slot2 idle, FIFO empty, lu dest=9 data=0x99 → accepted; next cycle rf_we2=1 addr9 0x99; q_count stays 0.
- FIFO holds two entries both with dest=3 (0x1, 0x2), ports idle → rf_we1=0; rf_we2=1 addr3 0x2.
- lu dest=0 accepted → no write, q_count unchanged. Reset with q_count=3 → next cycle q_count=0, pend_mask=0, rf_we1=rf_we2=0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: pipeline slots own their RF ports, long-latency
// results queue in a small FIFO and drain into idle ports in order.
module wb_port_arbiter #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          slot1_valid,
  input  logic          slot1_we,
  input  logic [4:0]    slot1_dest,
  input  logic [31:0]   slot1_data,
  input  logic [31:0]   slot1_pc,
  input  logic          slot2_valid,
  input  logic          slot2_we,
  input  logic [4:0]    slot2_dest,
  input  logic [31:0]   slot2_data,
  input  logic [31:0]   slot2_pc,
  input  logic          lu_valid,
  output logic          lu_ready,
  input  logic [4:0]    lu_dest,
  input  logic [31:0]   lu_data,
  input  logic [31:0]   lu_pc,
  output logic          rf_we1,
  output logic [4:0]    rf_waddr1,
  output logic [31:0]   rf_wdata1,
  output logic [31:0]   rf_pc1,
  output logic          rf_we2,
  output logic [4:0]    rf_waddr2,
  output logic [31:0]   rf_wdata2,
  output logic [31:0]   rf_pc2,
  output logic [31:0]   pend_mask,
  output logic [CW-1:0] q_count
);

  localparam int AW = $clog2(DEPTH);

  logic [4:0]       r_dest [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [31:0]      r_pc   [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  logic          w_busy1;
  logic          w_busy2;
  logic          w_enq;
  logic          w_av0;
  logic          w_av1;
  logic [AW-1:0] w_head1;
  logic [4:0]    w_c0_dest;
  logic [31:0]   w_c0_data;
  logic [31:0]   w_c0_pc;
  logic [4:0]    w_c1_dest;
  logic [31:0]   w_c1_data;
  logic [31:0]   w_c1_pc;
  logic          w_we1;
  logic [4:0]    w_a1;
  logic [31:0]   w_d1;
  logic [31:0]   w_p1;
  logic          w_we2;
  logic [4:0]    w_a2;
  logic [31:0]   w_d2;
  logic [31:0]   w_p2;
  logic [1:0]    w_pop;
  logic [CW-1:0] w_cnt_nxt;

  assign lu_ready = !reset && (r_count < CW'(DEPTH));
  assign q_count  = r_count;
  assign w_head1  = r_head + AW'(1);

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (r_vld[i]) pend_mask[r_dest[i]] = 1'b1;
  end

  // Candidates: queued entries first, then this cycle's accepted result.
  always_comb begin
    w_busy1 = slot1_valid && slot1_we;
    w_busy2 = slot2_valid && slot2_we;
    w_enq   = lu_valid && lu_ready && (lu_dest != 5'd0);
    w_av0   = (r_count != '0) || w_enq;
    w_av1   = (r_count > CW'(1)) ||
              ((r_count == CW'(1)) && w_enq);
    w_c0_dest = lu_dest;
    w_c0_data = lu_data;
    w_c0_pc   = lu_pc;
    w_c1_dest = lu_dest;
    w_c1_data = lu_data;
    w_c1_pc   = lu_pc;
    if (r_count != '0) begin
      w_c0_dest = r_dest[r_head];
      w_c0_data = r_data[r_head];
      w_c0_pc   = r_pc[r_head];
    end
    if (r_count > CW'(1)) begin
      w_c1_dest = r_dest[w_head1];
      w_c1_data = r_data[w_head1];
      w_c1_pc   = r_pc[w_head1];
    end
  end

  always_comb begin
    w_we1 = w_busy1;
    w_a1  = slot1_dest;
    w_d1  = slot1_data;
    w_p1  = slot1_pc;
    w_we2 = w_busy2;
    w_a2  = slot2_dest;
    w_d2  = slot2_data;
    w_p2  = slot2_pc;
    w_pop = 2'd0;
    unique case (1'b1)
      (!w_busy1 && !w_busy2): begin
        w_we1 = w_av0;
        w_a1  = w_c0_dest;
        w_d1  = w_c0_data;
        w_p1  = w_c0_pc;
        w_we2 = w_av1;
        w_a2  = w_c1_dest;
        w_d2  = w_c1_data;
        w_p2  = w_c1_pc;
        w_pop = {1'b0, w_av0} + {1'b0, w_av1};
      end
      (!w_busy1 && w_busy2): begin
        w_we1 = w_av0;
        w_a1  = w_c0_dest;
        w_d1  = w_c0_data;
        w_p1  = w_c0_pc;
        w_pop = {1'b0, w_av0};
      end
      (w_busy1 && !w_busy2): begin
        w_we2 = w_av0;
        w_a2  = w_c0_dest;
        w_d2  = w_c0_data;
        w_p2  = w_c0_pc;
        w_pop = {1'b0, w_av0};
      end
      default: ;
    endcase
    // Port 2 always holds the younger write.
    if (w_we1 && w_we2 && (w_a1 == w_a2)) w_we1 = 1'b0;
    w_cnt_nxt = r_count + CW'(w_enq) - CW'(w_pop);
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_dest[r_tail] <= lu_dest;
      r_data[r_tail] <= lu_data;
      r_pc[r_tail]   <= lu_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_vld     <= '0;
      rf_we1    <= 1'b0;
      rf_waddr1 <= '0;
      rf_wdata1 <= '0;
      rf_pc1    <= '0;
      rf_we2    <= 1'b0;
      rf_waddr2 <= '0;
      rf_wdata2 <= '0;
      rf_pc2    <= '0;
    end else begin
      if (w_enq) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + AW'(1);
      end
      if (w_pop != 2'd0) r_vld[r_head]  <= 1'b0;
      if (w_pop == 2'd2) r_vld[w_head1] <= 1'b0;
      r_head    <= r_head + AW'(w_pop);
      r_count   <= w_cnt_nxt;
      rf_we1    <= w_we1;
      rf_waddr1 <= w_we1 ? w_a1 : '0;
      rf_wdata1 <= w_we1 ? w_d1 : '0;
      rf_pc1    <= w_we1 ? w_p1 : '0;
      rf_we2    <= w_we2;
      rf_waddr2 <= w_we2 ? w_a2 : '0;
      rf_wdata2 <= w_we2 ? w_d2 : '0;
      rf_pc2    <= w_we2 ? w_p2 : '0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus random traffic,
// all checked against a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  typedef struct packed {
    logic [4:0]  d;
    logic [31:0] v;
    logic [31:0] pc;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          slot1_valid, slot1_we;
  logic [4:0]    slot1_dest;
  logic [31:0]   slot1_data, slot1_pc;
  logic          slot2_valid, slot2_we;
  logic [4:0]    slot2_dest;
  logic [31:0]   slot2_data, slot2_pc;
  logic          lu_valid, lu_ready;
  logic [4:0]    lu_dest;
  logic [31:0]   lu_data, lu_pc;
  logic          rf_we1, rf_we2;
  logic [4:0]    rf_waddr1, rf_waddr2;
  logic [31:0]   rf_wdata1, rf_wdata2;
  logic [31:0]   rf_pc1, rf_pc2;
  logic [31:0]   pend_mask;
  logic [CW-1:0] q_count;

  int n_chk  = 0;
  int n_pass = 0;

  ent_t mq[$];
  bit   last_acc;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .slot1_valid(slot1_valid), .slot1_we(slot1_we),
    .slot1_dest(slot1_dest), .slot1_data(slot1_data),
    .slot1_pc(slot1_pc),
    .slot2_valid(slot2_valid), .slot2_we(slot2_we),
    .slot2_dest(slot2_dest), .slot2_data(slot2_data),
    .slot2_pc(slot2_pc),
    .lu_valid(lu_valid), .lu_ready(lu_ready),
    .lu_dest(lu_dest), .lu_data(lu_data), .lu_pc(lu_pc),
    .rf_we1(rf_we1), .rf_waddr1(rf_waddr1),
    .rf_wdata1(rf_wdata1), .rf_pc1(rf_pc1),
    .rf_we2(rf_we2), .rf_waddr2(rf_waddr2),
    .rf_wdata2(rf_wdata2), .rf_pc2(rf_pc2),
    .pend_mask(pend_mask), .q_count(q_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock: check lu_ready, advance the model, check registered outputs.
  task automatic cyc();
    ent_t        cand[$];
    ent_t        e;
    logic        rdy;
    logic        we1, we2;
    logic [4:0]  a1, a2;
    logic [31:0] d1, d2, p1, p2;
    logic [31:0] pm;
    @(negedge clk);
    rdy = !reset && (mq.size() < DEPTH);
    chk("lu_ready", 32'(lu_ready), 32'(rdy));
    last_acc = lu_valid && rdy;
    we1 = 0; a1 = 0; d1 = 0; p1 = 0;
    we2 = 0; a2 = 0; d2 = 0; p2 = 0;
    if (reset) begin
      mq.delete();
    end else begin
      cand = mq;
      if (last_acc && lu_dest != 0)
        cand.push_back('{d: lu_dest, v: lu_data, pc: lu_pc});
      if (slot1_valid && slot1_we) begin
        we1 = 1; a1 = slot1_dest; d1 = slot1_data; p1 = slot1_pc;
      end else if (cand.size() > 0) begin
        e = cand.pop_front();
        we1 = 1; a1 = e.d; d1 = e.v; p1 = e.pc;
      end
      if (slot2_valid && slot2_we) begin
        we2 = 1; a2 = slot2_dest; d2 = slot2_data; p2 = slot2_pc;
      end else if (cand.size() > 0) begin
        e = cand.pop_front();
        we2 = 1; a2 = e.d; d2 = e.v; p2 = e.pc;
      end
      if (we1 && we2 && a1 == a2) begin
        we1 = 0; a1 = 0; d1 = 0; p1 = 0;
      end
      mq = cand;
    end
    pm = 0;
    foreach (mq[i]) pm[mq[i].d] = 1'b1;
    @(posedge clk);
    #1;
    chk("rf_we1", 32'(rf_we1), 32'(we1));
    chk("rf_waddr1", 32'(rf_waddr1), 32'(a1));
    chk("rf_wdata1", rf_wdata1, d1);
    chk("rf_pc1", rf_pc1, p1);
    chk("rf_we2", 32'(rf_we2), 32'(we2));
    chk("rf_waddr2", 32'(rf_waddr2), 32'(a2));
    chk("rf_wdata2", rf_wdata2, d2);
    chk("rf_pc2", rf_pc2, p2);
    chk("q_count", 32'(q_count), 32'(mq.size()));
    chk("pend_mask", pend_mask, pm);
  endtask

  task automatic slots(input logic v1, input logic [4:0] dd1,
                       input logic [31:0] x1,
                       input logic v2, input logic [4:0] dd2,
                       input logic [31:0] x2);
    slot1_valid = v1; slot1_we = v1; slot1_dest = dd1;
    slot1_data = x1; slot1_pc = 32'h1000 + x1;
    slot2_valid = v2; slot2_we = v2; slot2_dest = dd2;
    slot2_data = x2; slot2_pc = 32'h2000 + x2;
  endtask

  task automatic lu(input logic v, input logic [4:0] dd,
                    input logic [31:0] x);
    lu_valid = v; lu_dest = dd; lu_data = x; lu_pc = 32'h3000 + x;
  endtask

  initial begin
    int nxt;
    reset = 1;
    slots(0, 0, 0, 0, 0, 0);
    lu(0, 0, 0);
    cyc();
    cyc();
    chk("rst_q", 32'(q_count), 0);
    reset = 0;

    slots(1, 5, 32'h11, 1, 6, 32'h22);
    cyc();
    chk("pair_a1", 32'(rf_waddr1), 5);
    chk("pair_d2", rf_wdata2, 32'h22);

    slots(1, 7, 32'hAA, 1, 7, 32'hBB);
    cyc();
    chk("same_we1", 32'(rf_we1), 0);
    chk("same_d2", rf_wdata2, 32'hBB);

    nxt = 1;
    slots(1, 10, 32'h5, 1, 11, 32'h6);
    for (int k = 0; k < 6; k++) begin
      lu(1, 5'(nxt), 32'(nxt) << 8);
      cyc();
      if (last_acc) nxt++;
    end
    chk("full_acc", 32'(nxt), 5);
    chk("full_q", 32'(q_count), 4);
    chk("full_pm", pend_mask, 32'h1E);
    chk("full_rdy", 32'(lu_ready), 0);
    slots(0, 0, 0, 0, 0, 0);
    lu(0, 0, 0);
    cyc();
    chk("drain_a1", 32'(rf_waddr1), 1);
    chk("drain_a2", 32'(rf_waddr2), 2);
    cyc();
    chk("drain_a2b", 32'(rf_waddr2), 4);
    chk("drain_pm", pend_mask, 0);

    slots(1, 10, 32'h7, 0, 0, 0);
    lu(1, 9, 32'h99);
    cyc();
    chk("byp_we2", 32'(rf_we2), 1);
    chk("byp_d2", rf_wdata2, 32'h99);
    chk("byp_q", 32'(q_count), 0);

    slots(1, 10, 32'h8, 1, 11, 32'h9);
    lu(1, 3, 32'h1);
    cyc();
    lu(1, 3, 32'h2);
    cyc();
    slots(0, 0, 0, 0, 0, 0);
    lu(0, 0, 0);
    cyc();
    chk("qsame_we1", 32'(rf_we1), 0);
    chk("qsame_d2", rf_wdata2, 32'h2);

    lu(1, 0, 32'h55);
    cyc();
    chk("zero_we1", 32'(rf_we1), 0);
    chk("zero_we2", 32'(rf_we2), 0);

    slots(1, 10, 32'h1, 1, 11, 32'h2);
    for (int k = 1; k <= 3; k++) begin
      lu(1, 5'(k + 20), 32'(k));
      cyc();
    end
    chk("pre_rst_q", 32'(q_count), 3);
    reset = 1;
    lu(0, 0, 0);
    cyc();
    reset = 0;
    chk("mid_rst_q", 32'(q_count), 0);
    chk("mid_rst_pm", pend_mask, 0);
    chk("mid_rst_we", 32'({rf_we1, rf_we2}), 0);

    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 99) == 0);
      slot1_valid = ($urandom_range(0, 9) < 6);
      slot1_we    = ($urandom_range(0, 3) != 0);
      slot1_dest  = 5'($urandom_range(0, 31));
      slot1_data  = $urandom;
      slot1_pc    = $urandom;
      slot2_valid = ($urandom_range(0, 9) < 6);
      slot2_we    = ($urandom_range(0, 3) != 0);
      slot2_dest  = ($urandom_range(0, 1) == 0) ? slot1_dest
                                                : 5'($urandom_range(0, 31));
      slot2_data  = $urandom;
      slot2_pc    = $urandom;
      lu_valid    = ($urandom_range(0, 9) < 6);
      lu_dest     = 5'($urandom_range(0, 7));
      lu_data     = $urandom;
      lu_pc       = $urandom;
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
